// File: rtl/fetch_sched.sv
// Instruction fetch scheduler: drives PC update pulses, requests instruction
// words from memory and offers each fetched word to the decoder.
module fetch_sched #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    input  logic              inst_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            inst  <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && imem_ack)
                inst <= imem_data;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_target  = '0;
        imem_req   = 1'b0;
        imem_addr  = '0;
        inst_valid = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE, HALTED: begin
                halted = (state == HALTED);
                if (start) begin
                    pc_load   = 1'b1;
                    pc_target = start_addr;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                imem_req  = 1'b1;
                imem_addr = pc_addr;
                if (imem_ack) begin
                    pc_inc    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy       = 1'b1;
                inst_valid = 1'b1;
                // PC already advanced on the ack; only a branch touches it here.
                if (inst_ready) begin
                    if (halt) begin
                        state_nxt = HALTED;
                    end else if (branch_taken) begin
                        pc_load   = 1'b1;
                        pc_target = branch_target;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sched.sv
// Directed bench for fetch_sched: stimulus queues expected fetch addresses,
// issued words and PC loads; a negedge monitor pops and compares them.
module tb_fetch_sched;

    localparam int ADDR_W = 16;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              reset, start, imem_ack, inst_ready, branch_taken, halt;
    logic [ADDR_W-1:0] start_addr, pc_addr, branch_target;
    logic [ADDR_W-1:0] pc_target, imem_addr;
    logic [INST_W-1:0] imem_data, inst;
    logic              pc_inc, pc_load, imem_req, inst_valid, busy, halted;

    int checks = 0;
    int fails  = 0;

    logic [ADDR_W-1:0] exp_fetch[$];
    logic [INST_W-1:0] exp_inst[$];
    logic [ADDR_W-1:0] exp_load[$];

    fetch_sched #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .pc_addr(pc_addr), .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .inst_valid(inst_valid), .inst(inst),
        .inst_ready(inst_ready), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt(halt), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] mem(input logic [ADDR_W-1:0] a);
        return {~a, a};
    endfunction

    // Memory returns garbage unless acknowledging, so a premature capture shows up.
    assign imem_data = imem_ack ? mem(imem_addr) : 32'hBAD0_BAD0;

    // External PC register; deliberately not reset by the scheduler's reset.
    initial pc_addr = 16'h1234;
    always @(posedge clk) begin
        if (pc_load === 1'b1)     pc_addr <= pc_target;
        else if (pc_inc === 1'b1) pc_addr <= pc_addr + 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        fails++;
        $display("FAIL %s: event with no expected entry at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_pc_inc"},     pc_inc,     0);
        chk({tag, "_pc_load"},    pc_load,    0);
        chk({tag, "_pc_target"},  pc_target,  0);
        chk({tag, "_imem_req"},   imem_req,   0);
        chk({tag, "_imem_addr"},  imem_addr,  0);
        chk({tag, "_inst_valid"}, inst_valid, 0);
        chk({tag, "_inst"},       inst,       0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_halted"},     halted,     0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (imem_req && imem_ack) begin
                if (exp_fetch.size() == 0) unexpected("fetch");
                else chk("fetch_addr", imem_addr, exp_fetch.pop_front());
            end
            if (inst_valid && inst_ready) begin
                if (exp_inst.size() == 0) unexpected("issue");
                else chk("issue_inst", inst, exp_inst.pop_front());
            end
            if (pc_load) begin
                if (exp_load.size() == 0) unexpected("pc_load");
                else chk("pc_target", pc_target, exp_load.pop_front());
            end else begin
                chk("target_zero", pc_target, 0);
            end
            chk("inc_load_excl", pc_inc && pc_load, 0);
            chk("inc_on_ack", pc_inc, imem_req && imem_ack);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; start = 0; start_addr = '0; imem_ack = 0; inst_ready = 0;
        branch_taken = 0; branch_target = '0; halt = 0;
        step(); step();
        reset = 0;
        chk_idle_outputs("reset");

        // Cold start, zero-wait memory, halt on the third issue
        exp_load.push_back(16'h0010);
        for (int unsigned i = 0; i < 3; i++) begin
            exp_fetch.push_back(16'h0010 + i[15:0]);
            exp_inst.push_back(mem(16'h0010 + i[15:0]));
        end
        step();
        start = 1; start_addr = 16'h0010; imem_ack = 1; inst_ready = 1;
        step();
        start = 0;
        @(negedge clk);
        chk("cold_req_latency", imem_req, 1);
        repeat (5) step();
        halt = 1;
        step();
        halt = 0;
        @(negedge clk);
        chk("cold_halted", halted, 1);
        chk("cold_busy", busy, 0);

        // Three wait states, decoder stalled when the word arrives
        imem_ack = 0; inst_ready = 0;
        exp_load.push_back(16'h0020);
        exp_fetch.push_back(16'h0020);
        exp_inst.push_back(mem(16'h0020));
        start = 1; start_addr = 16'h0020;
        step();
        start = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, 16'h0020);
            chk("wait_no_inc", pc_inc, 0);
            step();
        end
        imem_ack = 1;
        @(negedge clk);
        chk("ack_req", imem_req, 1);
        chk("ack_addr", imem_addr, 16'h0020);
        step();
        imem_ack = 0;

        // Decoder stall; halt/branch offered without handshake must be ignored
        halt = 1; branch_taken = 1; branch_target = 16'h0099;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", inst_valid, 1);
            chk("stall_inst", inst, mem(16'h0020));
            chk("stall_no_req", imem_req, 0);
            chk("stall_no_inc", pc_inc, 0);
            chk("stall_no_load", pc_load, 0);
            step();
        end

        // Branch at handshake; ack raised during ISSUE must not matter
        halt = 0; branch_taken = 1; branch_target = 16'h0040; inst_ready = 1; imem_ack = 1;
        exp_load.push_back(16'h0040);
        exp_fetch.push_back(16'h0040);
        exp_inst.push_back(mem(16'h0040));
        step();
        branch_taken = 0;
        step();
        halt = 1; branch_taken = 1; branch_target = 16'h0077;
        step();
        halt = 0; branch_taken = 0;
        @(negedge clk);
        chk("branch_halt_halted", halted, 1);

        // Reset mid-fetch, late ack, restart at 0
        imem_ack = 0;
        exp_load.push_back(16'h0050);
        start = 1; start_addr = 16'h0050;
        step();
        start = 0;
        step();
        reset = 1;
        step();
        reset = 0; imem_ack = 1;
        chk_idle_outputs("late_ack");
        step();
        @(negedge clk);
        chk("late_ack_busy", busy, 0);
        exp_load.push_back(16'h0000);
        exp_fetch.push_back(16'h0000);
        exp_inst.push_back(mem(16'h0000));
        start = 1; start_addr = 16'h0000;
        step();
        start = 0;
        step();
        halt = 1;
        step();
        halt = 0;
        @(negedge clk);
        chk("restart_halted", halted, 1);

        step();
        chk("left_fetch", exp_fetch.size(), 0);
        chk("left_inst", exp_inst.size(), 0);
        chk("left_load", exp_load.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fetch_sched.md
FETCH_SCHED -- requirements
Module: fetch_sched

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the instruction-memory address width, equal to the PC width.
REQ-002 Parameter INST_W, default 32, SHALL set the instruction word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin execution at start_addr; honoured only in IDLE or HALTED.
REQ-006 start_addr  input  ADDR_W  entry address.
REQ-007 pc_addr  input  ADDR_W  current PC register value.
REQ-008 pc_inc  output  1  one-cycle pulse: PC increments.
REQ-009 pc_load  output  1  one-cycle pulse: PC loads pc_target.
REQ-010 pc_target  output  ADDR_W  value for PC load.
REQ-011 imem_req  output  1  instruction-memory read request.
REQ-012 imem_addr  output  ADDR_W  read address.
REQ-013 imem_ack  input  1  read data valid on imem_data this cycle.
REQ-014 imem_data  input  INST_W  read data.
REQ-015 inst_valid  output  1  fetched instruction offered to the decoder.
REQ-016 inst  output  INST_W  registered instruction word.
REQ-017 inst_ready  input  1  decoder accepts inst.
REQ-018 branch_taken  input  1  branch redirect; sampled only on the issue handshake.
REQ-019 branch_target  input  ADDR_W  redirect address.
REQ-020 halt  input  1  issued instruction is HALT; sampled only on the issue handshake.
REQ-021 busy  output  1  high in FETCH and ISSUE.
REQ-022 halted  output  1  high in HALTED.

Function
REQ-023 The FSM SHALL have exactly four states: IDLE, FETCH, ISSUE, HALTED.
REQ-024 In IDLE or HALTED with start=1: pc_load=1 and pc_target=start_addr that cycle; next state is FETCH.
REQ-025 In IDLE or HALTED with start=0: the state SHALL be held and pc_inc, pc_load and imem_req SHALL be 0.
REQ-026 In FETCH: imem_req=1 and imem_addr=pc_addr; the request SHALL be held with a stable address until imem_ack.
REQ-027 In FETCH with imem_ack=1: imem_data is captured into inst, pc_inc=1 for that cycle, and next state is ISSUE.
- Acknowledge may arrive in the same cycle as the request, giving zero wait states.
REQ-028 In ISSUE: inst_valid=1 and inst SHALL be held stable until inst_valid and inst_ready are both high (handshake).
REQ-029 On the ISSUE handshake, priority SHALL be halt > branch_taken > sequential:
- halt=1: next state HALTED; no PC pulse.
- branch_taken=1: pc_load=1, pc_target=branch_target; next state FETCH.
- otherwise: next state FETCH with no PC pulse, because the increment was already applied on ack.
REQ-030 pc_inc and pc_load SHALL never be high in the same cycle; each SHALL be high for at most one cycle per event.
REQ-031 pc_target SHALL be 0 whenever pc_load=0.
REQ-032 branch_taken and halt SHALL be ignored outside the ISSUE handshake cycle.
REQ-033 imem_ack outside FETCH SHALL be ignored.
REQ-034 start while busy=1 SHALL be ignored.
REQ-035 Latency: start at cycle T gives imem_req at T+1. An ack at cycle A gives inst_valid at A+1. The next imem_req follows 1 cycle after the handshake.
REQ-036 PC wrap-around is owned by the PC register; this block imposes no address bound.

Reset
REQ-037 With reset=1 at a rising edge, the state SHALL become IDLE from any state, including mid-fetch and mid-issue.
REQ-038 Reset values: inst=0, and pc_inc, pc_load, pc_target, imem_req, imem_addr, inst_valid, busy and halted all 0.
REQ-039 An outstanding memory request SHALL be abandoned at reset; a late imem_ack after reset SHALL be ignored.

Verification
REQ-040 Cold start, zero-wait memory:
- Stimulus: start, start_addr=0x0010; imem_ack tied high; inst_ready high.
- Response: pc_load pulse at T; fetches at 0x0010, 0x0011, 0x0012 every 2 cycles, each with one pc_inc pulse.
REQ-041 Memory wait states:
- Stimulus: imem_ack delayed 3 cycles.
- Response: imem_req and imem_addr held 4 cycles; inst latched only on the ack cycle.
REQ-042 Decoder stall:
- Stimulus: inst_ready low for 5 cycles.
- Response: inst_valid high and inst constant throughout; no imem_req; no PC pulse.
REQ-043 Branch and halt together:
- Stimulus: branch_taken=1 with branch_target=0x0040 at one handshake; a later handshake with halt=1 and branch_taken=1.
- Response: the first fetch after the branch is at 0x0040; the second handshake enters HALTED with no pc_load.
REQ-044 Reset mid-fetch, then restart:
- Stimulus: reset during FETCH, then a late imem_ack, then start with start_addr=0x0000.
- Response: IDLE with all outputs 0; the late ack is ignored; the restart fetch is at 0x0000.
